write_slave: RTL and testbench
==============================

WRITE_SLAVE -- requirements
Module: write_slave

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: width of the write byte address; legal 5..32.
REQ-002 ACLK  input  1  sole clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 AWVALID  input  1  write-address valid from master.
REQ-005 AWADDR  input  ADDR_WIDTH  write byte address.
REQ-006 AWPROT  input  3  protection bits; accepted and ignored.
REQ-007 AWREADY  output  1  write-address ready.
REQ-008 WVALID  input  1  write-data valid from master.
REQ-009 WDATA  input  32  write data.
REQ-010 WSTRB  input  4  byte strobes, bit i enables WDATA[8i+7:8i].
REQ-011 WREADY  output  1  write-data ready.
REQ-012 BVALID  output  1  write-response valid.
REQ-013 BRESP  output  2  write response: 2'b00 OKAY, 2'b10 SLVERR.
REQ-014 BREADY  input  1  write-response ready from master.
REQ-015 o_REGS  output  128  register file, reg k at bits [32k+31:32k], k=0..3.

Function
REQ-016 Four 32-bit registers; word index = AWADDR[3:2]; AWADDR[1:0] ignored.
REQ-017 AW handshake = AWVALID&&AWREADY at a rising edge; W handshake = WVALID&&WREADY likewise.
REQ-018 AW and W are accepted independently and in either order; each is captured into its own holding register and flag (aw_held, w_held).
REQ-019 AWREADY = !rst && !aw_held && !BVALID; WREADY = !rst && !w_held && !BVALID; both are decoded from registered state only, with no combinational path from any input.
REQ-020 States: IDLE (neither held), HAVE_AW, HAVE_W, RESP (BVALID=1).
REQ-021 Transitions: IDLE -> HAVE_AW on AW only, -> HAVE_W on W only, -> RESP on both in the same cycle; HAVE_AW -> RESP on W; HAVE_W -> RESP on AW; RESP -> IDLE on BVALID&&BREADY.
REQ-022 Commit: at the edge completing the second handshake (or both together), the addressed register is written using held or live address/data as applicable; only strobed bytes change.
REQ-023 BVALID rises on the cycle after commit; latency from both handshakes complete to BVALID = 1 cycle.
REQ-024 BVALID and BRESP remain stable until BVALID&&BREADY; BVALID falls, and ready outputs rise, on the following cycle.
REQ-025 No new AW or W is accepted while BVALID=1; at most one outstanding transaction.
REQ-026 WSTRB=4'b0000 commits nothing to the registers but still returns a response per REQ-032/033.
REQ-027 AWVALID/WVALID deasserted before handshake is legal and leaves state unchanged.
REQ-028 BREADY held high before BVALID is legal; the response completes in the first BVALID cycle.
REQ-029 o_REGS reflects register contents continuously (registered, not bypassed).

Reset
REQ-030 While rst=1: o_REGS=0, BVALID=0, BRESP=2'b00, AWREADY=0, WREADY=0, holding flags cleared, state IDLE.
REQ-031 rst asserted mid-transaction (held AW/W or pending BVALID) aborts it with no register write and no response; AWREADY=WREADY=1 in the first cycle after release.

Configuration
REQ-032 Macro WRITE_SLAVE_SLVERR_EN defined: AWADDR[ADDR_WIDTH-1:4] != 0 yields BRESP=2'b10 with no register write; in-range yields 2'b00.
REQ-033 Macro undefined: upper address bits are ignored (aliasing onto the 4 registers), every transaction is written and BRESP is always 2'b00.

Verification
REQ-034 AW=0x4 and W=0xDEADBEEF/STRB=4'hF in the same cycle, BREADY=1 -> BVALID next cycle, BRESP=00, o_REGS[63:32]=0xDEADBEEF.
REQ-035 W=0x12345678 STRB=4'h5 first, AW=0x8 three cycles later -> reg2 = 0x00340078; AWREADY and WREADY low from W acceptance until response done.
REQ-036 AW=0xC, W=0xCAFEF00D, BREADY held 0 for 5 cycles -> BVALID/BRESP stable 5 cycles, second AWVALID not accepted; BREADY=1 -> BVALID drops next cycle.
REQ-037 AW=0x10, W=0xFFFFFFFF -> with WRITE_SLAVE_SLVERR_EN: BRESP=10, registers unchanged; without: BRESP=00, reg0=0xFFFFFFFF.
REQ-038 rst pulsed while AW=0x0 is held awaiting W -> no write, BVALID=0, o_REGS=0, both readies 1 after release.

Source files
------------

// File: rtl/write_slave.sv
// write_slave: write-only slave with four 32-bit registers and independent AW/W acceptance.
// Optional macro WRITE_SLAVE_SLVERR_EN: out-of-range addresses return SLVERR and skip the write.
module write_slave #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  ACLK,
  input  logic                  rst,
  input  logic                  AWVALID,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic [2:0]            AWPROT,
  output logic                  AWREADY,
  input  logic                  WVALID,
  input  logic [31:0]           WDATA,
  input  logic [3:0]            WSTRB,
  output logic                  WREADY,
  output logic                  BVALID,
  output logic [1:0]            BRESP,
  input  logic                  BREADY,
  output logic [127:0]          o_REGS
);

  typedef enum logic [1:0] {StIdle, StHaveAw, StHaveW, StResp} state_e;

  state_e                state_q;
  logic                  aw_held_q;
  logic                  w_held_q;
  logic                  bvalid_q;
  logic [1:0]            bresp_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           data_q;
  logic [3:0]            strb_q;
  logic [31:0]           regs_q [4];

  logic                  aw_hs;
  logic                  w_hs;
  logic                  commit;
  logic                  addr_err;
  logic [ADDR_WIDTH-1:0] addr_eff;
  logic [31:0]           data_eff;
  logic [3:0]            strb_eff;
  logic [1:0]            word_idx;

  // Readies depend only on registered state (and reset), never on the master's valids.
  assign AWREADY = !rst && !aw_held_q && !bvalid_q;
  assign WREADY  = !rst && !w_held_q && !bvalid_q;
  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;

  assign aw_hs = AWVALID && AWREADY;
  assign w_hs  = WVALID && WREADY;

  // Held flags are cleared on commit, so this fires only on the edge completing the pair.
  assign commit = (aw_hs || aw_held_q) && (w_hs || w_held_q);

  assign addr_eff = aw_held_q ? addr_q : AWADDR;
  assign data_eff = w_held_q ? data_q : WDATA;
  assign strb_eff = w_held_q ? strb_q : WSTRB;
  assign word_idx = addr_eff[3:2];

`ifdef WRITE_SLAVE_SLVERR_EN
  assign addr_err = |addr_eff[ADDR_WIDTH-1:4];
`else
  assign addr_err = 1'b0;
`endif

  logic unused_bits;
  assign unused_bits = ^{AWPROT, addr_eff};

  always_ff @(posedge ACLK or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      addr_q    <= '0;
      data_q    <= '0;
      strb_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle, StHaveAw, StHaveW: begin
          if (commit) begin
            state_q   <= StResp;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            bvalid_q  <= 1'b1;
            bresp_q   <= addr_err ? 2'b10 : 2'b00;
          end else begin
            if (aw_hs) begin
              state_q   <= StHaveAw;
              aw_held_q <= 1'b1;
              addr_q    <= AWADDR;
            end
            if (w_hs) begin
              state_q  <= StHaveW;
              w_held_q <= 1'b1;
              data_q   <= WDATA;
              strb_q   <= WSTRB;
            end
          end
        end
        StResp: begin
          if (BREADY) begin
            state_q  <= StIdle;
            bvalid_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge ACLK or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        regs_q[k] <= '0;
      end
    end else if (commit && !addr_err) begin
      for (int b = 0; b < 4; b++) begin
        if (strb_eff[b]) begin
          regs_q[word_idx][8*b +: 8] <= data_eff[8*b +: 8];
        end
      end
    end
  end

  assign o_REGS = {regs_q[3], regs_q[2], regs_q[1], regs_q[0]};

endmodule

// File: tb/tb_write_slave.sv
// Self-checking bench for write_slave: directed scenarios plus randomized transactions
// checked against a byte-level register model.
`timescale 1ns/1ps
module tb_write_slave;

  localparam int unsigned AW = 32;
`ifdef WRITE_SLAVE_SLVERR_EN
  localparam bit SlvErrEn = 1'b1;
`else
  localparam bit SlvErrEn = 1'b0;
`endif

  logic          ACLK = 1'b0;
  logic          rst;
  logic          AWVALID;
  logic [AW-1:0] AWADDR;
  logic [2:0]    AWPROT;
  logic          AWREADY;
  logic          WVALID;
  logic [31:0]   WDATA;
  logic [3:0]    WSTRB;
  logic          WREADY;
  logic          BVALID;
  logic [1:0]    BRESP;
  logic          BREADY;
  logic [127:0]  o_REGS;

  always #5 ACLK = ~ACLK;

  write_slave #(.ADDR_WIDTH(AW)) dut (
    .ACLK    (ACLK),
    .rst     (rst),
    .AWVALID (AWVALID),
    .AWADDR  (AWADDR),
    .AWPROT  (AWPROT),
    .AWREADY (AWREADY),
    .WVALID  (WVALID),
    .WDATA   (WDATA),
    .WSTRB   (WSTRB),
    .WREADY  (WREADY),
    .BVALID  (BVALID),
    .BRESP   (BRESP),
    .BREADY  (BREADY),
    .o_REGS  (o_REGS)
  );

  int checks = 0;
  int fails  = 0;

  logic [31:0] model [4];

  // Observations returned by drive_txn.
  bit       obs_to;
  bit       obs_leak;
  bit       obs_stable;
  logic     obs_bv_first;
  logic     obs_bv_after;
  logic [1:0] obs_resp;
  logic [1:0] obs_rdy_after;

  function automatic logic [1:0] exp_resp(input logic [31:0] a);
    return (SlvErrEn && ((a >> 4) != 0)) ? 2'b10 : 2'b00;
  endfunction

  function automatic logic [127:0] model_regs();
    return {model[3], model[2], model[1], model[0]};
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 4; k++) model[k] = 32'h0;
  endtask

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (exp_resp(a) != 2'b00) return;
    for (int b = 0; b < 4; b++) if (s[b]) model[a[3:2]][8*b +: 8] = d[8*b +: 8];
  endtask

  // aw_dly/w_dly: cycles before presenting each channel; b_dly < 0 holds BREADY high early.
  // poke: during response backpressure, offer a second AW and W that must not be taken.
  task automatic drive_txn(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly,
                           input int b_dly, input bit poke);
    bit aw_done = 0;
    bit w_done  = 0;
    int cyc     = 0;
    obs_to = 0; obs_leak = 0; obs_stable = 1;
    BREADY = (b_dly < 0);
    while (!(aw_done && w_done)) begin
      @(negedge ACLK);
      if ((aw_done && AWREADY) || (w_done && WREADY)) obs_leak = 1;
      AWVALID = !aw_done && (cyc >= aw_dly);
      AWADDR  = addr;
      WVALID  = !w_done && (cyc >= w_dly);
      WDATA   = data;
      WSTRB   = strb;
      if (AWVALID && AWREADY) aw_done = 1;
      if (WVALID && WREADY) w_done = 1;
      cyc++;
      if (cyc > 100) begin
        obs_to = 1;
        break;
      end
    end
    @(negedge ACLK);
    AWVALID = 0; WVALID = 0;
    obs_bv_first = BVALID;
    obs_resp     = BRESP;
    if (AWREADY || WREADY) obs_leak = 1;
    for (int i = 0; i < b_dly; i++) begin
      if (poke) begin
        AWVALID = 1; AWADDR = 32'h0; WVALID = 1; WDATA = 32'hBAD0BAD0; WSTRB = 4'hF;
      end
      @(negedge ACLK);
      if (BVALID !== 1'b1 || BRESP !== obs_resp) obs_stable = 0;
      if (AWREADY || WREADY) obs_leak = 1;
    end
    AWVALID = 0; WVALID = 0; BREADY = 1;
    @(negedge ACLK);
    obs_bv_after  = BVALID;
    obs_rdy_after = {AWREADY, WREADY};
    BREADY = 0;
  endtask

  task automatic test_reset();
    rst = 1; AWVALID = 1; WVALID = 1; BREADY = 1;
    AWADDR = 32'h4; AWPROT = 3'b010; WDATA = 32'hFFFFFFFF; WSTRB = 4'hF;
    repeat (3) @(negedge ACLK);
    checks++; if (AWREADY !== 1'b0) begin fails++; $display("FAIL reset_awready: got %b want 0", AWREADY); end
    checks++; if (WREADY !== 1'b0) begin fails++; $display("FAIL reset_wready: got %b want 0", WREADY); end
    checks++; if (BVALID !== 1'b0) begin fails++; $display("FAIL reset_bvalid: got %b want 0", BVALID); end
    checks++; if (BRESP !== 2'b00) begin fails++; $display("FAIL reset_bresp: got %b want 00", BRESP); end
    checks++; if (o_REGS !== 128'h0) begin fails++; $display("FAIL reset_regs: got %h want 0", o_REGS); end
    AWVALID = 0; WVALID = 0; BREADY = 0;
    rst = 0;
    #1;
    checks++; if ({AWREADY, WREADY} !== 2'b11) begin fails++; $display("FAIL reset_release_ready: got %b want 11", {AWREADY, WREADY}); end
    model_clear();
  endtask

  task automatic test_same_cycle();
    drive_txn(32'h4, 32'hDEADBEEF, 4'hF, 0, 0, -1, 0);
    model_write(32'h4, 32'hDEADBEEF, 4'hF);
    checks++; if (obs_to) begin fails++; $display("FAIL same_timeout: got 1 want 0"); end
    checks++; if (obs_bv_first !== 1'b1) begin fails++; $display("FAIL same_bvalid_lat: got %b want 1", obs_bv_first); end
    checks++; if (obs_resp !== 2'b00) begin fails++; $display("FAIL same_bresp: got %b want 00", obs_resp); end
    checks++; if (o_REGS[63:32] !== 32'hDEADBEEF) begin fails++; $display("FAIL same_reg1: got %h want deadbeef", o_REGS[63:32]); end
    checks++; if (obs_bv_after !== 1'b0) begin fails++; $display("FAIL same_bvalid_drop: got %b want 0", obs_bv_after); end
    checks++; if (obs_rdy_after !== 2'b11) begin fails++; $display("FAIL same_ready_after: got %b want 11", obs_rdy_after); end
  endtask

  task automatic test_w_first();
    drive_txn(32'h8, 32'h12345678, 4'h5, 3, 0, 0, 0);
    model_write(32'h8, 32'h12345678, 4'h5);
    checks++; if (obs_to) begin fails++; $display("FAIL wfirst_timeout: got 1 want 0"); end
    checks++; if (o_REGS[95:64] !== 32'h00340078) begin fails++; $display("FAIL wfirst_reg2: got %h want 00340078", o_REGS[95:64]); end
    checks++; if (obs_leak) begin fails++; $display("FAIL wfirst_ready_low: got ready high want low"); end
    checks++; if (o_REGS !== model_regs()) begin fails++; $display("FAIL wfirst_regs: got %h want %h", o_REGS, model_regs()); end
  endtask

  task automatic test_backpressure();
    drive_txn(32'hC, 32'hCAFEF00D, 4'hF, 0, 0, 5, 1);
    model_write(32'hC, 32'hCAFEF00D, 4'hF);
    checks++; if (obs_bv_first !== 1'b1) begin fails++; $display("FAIL bp_bvalid: got %b want 1", obs_bv_first); end
    checks++; if (!obs_stable) begin fails++; $display("FAIL bp_stable: got unstable want stable"); end
    checks++; if (obs_leak) begin fails++; $display("FAIL bp_no_accept: got ready high want low"); end
    checks++; if (obs_bv_after !== 1'b0) begin fails++; $display("FAIL bp_bvalid_drop: got %b want 0", obs_bv_after); end
    checks++; if (o_REGS !== model_regs()) begin fails++; $display("FAIL bp_regs: got %h want %h", o_REGS, model_regs()); end
  endtask

  task automatic test_out_of_range();
    drive_txn(32'h10, 32'hFFFFFFFF, 4'hF, 0, 0, 0, 0);
    checks++; if (obs_resp !== exp_resp(32'h10)) begin fails++; $display("FAIL oor_bresp: got %b want %b", obs_resp, exp_resp(32'h10)); end
    model_write(32'h10, 32'hFFFFFFFF, 4'hF);
    checks++; if (o_REGS !== model_regs()) begin fails++; $display("FAIL oor_regs: got %h want %h", o_REGS, model_regs()); end
  endtask

  task automatic test_reset_mid();
    @(negedge ACLK);
    AWVALID = 1; AWADDR = 32'h0;
    @(negedge ACLK);
    AWVALID = 0;
    checks++; if ({AWREADY, WREADY} !== 2'b01) begin fails++; $display("FAIL mid_held_ready: got %b want 01", {AWREADY, WREADY}); end
    rst = 1; WVALID = 1; WDATA = 32'h11111111; WSTRB = 4'hF;
    @(negedge ACLK);
    WVALID = 0; rst = 0;
    #1;
    checks++; if ({AWREADY, WREADY} !== 2'b11) begin fails++; $display("FAIL mid_ready_release: got %b want 11", {AWREADY, WREADY}); end
    @(negedge ACLK);
    checks++; if (BVALID !== 1'b0) begin fails++; $display("FAIL mid_bvalid: got %b want 0", BVALID); end
    checks++; if (o_REGS !== 128'h0) begin fails++; $display("FAIL mid_regs: got %h want 0", o_REGS); end
    // Abort a pending response.
    AWVALID = 1; AWADDR = 32'h4; WVALID = 1; WDATA = 32'h55AA55AA; WSTRB = 4'hF; BREADY = 0;
    @(negedge ACLK);
    AWVALID = 0; WVALID = 0;
    checks++; if (BVALID !== 1'b1) begin fails++; $display("FAIL mid_pend_bvalid: got %b want 1", BVALID); end
    rst = 1;
    #1;
    checks++; if (BVALID !== 1'b0) begin fails++; $display("FAIL mid_abort_bvalid: got %b want 0", BVALID); end
    @(negedge ACLK);
    rst = 0;
    @(negedge ACLK);
    checks++; if (BVALID !== 1'b0 || o_REGS !== 128'h0) begin fails++; $display("FAIL mid_abort_after: got bvalid=%b regs=%h want 0/0", BVALID, o_REGS); end
    model_clear();
  endtask

  task automatic test_random();
    logic [31:0] a, d;
    logic [3:0]  s;
    int          bd;
    for (int n = 0; n < 40; n++) begin
      a  = (($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFFFFF0) : 32'h0) | ($urandom & 32'hF);
      d  = $urandom;
      s  = 4'($urandom_range(0, 15));
      bd = int'($urandom_range(0, 4)) - 1;
      drive_txn(a, d, s, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), bd,
                1'($urandom_range(0, 1)));
      checks++; if (obs_to) begin fails++; $display("FAIL rnd_timeout[%0d]: got 1 want 0", n); end
      checks++; if (obs_bv_first !== 1'b1) begin fails++; $display("FAIL rnd_bvalid[%0d]: got %b want 1", n, obs_bv_first); end
      checks++; if (obs_resp !== exp_resp(a)) begin fails++; $display("FAIL rnd_bresp[%0d]: got %b want %b", n, obs_resp, exp_resp(a)); end
      checks++; if (obs_leak || !obs_stable) begin fails++; $display("FAIL rnd_handshake[%0d]: got leak=%b stable=%b want 0/1", n, obs_leak, obs_stable); end
      checks++; if (obs_bv_after !== 1'b0) begin fails++; $display("FAIL rnd_bdrop[%0d]: got %b want 0", n, obs_bv_after); end
      model_write(a, d, s);
      checks++; if (o_REGS !== model_regs()) begin fails++; $display("FAIL rnd_regs[%0d]: got %h want %h", n, o_REGS, model_regs()); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1; AWVALID = 0; WVALID = 0; BREADY = 0;
    AWADDR = '0; AWPROT = '0; WDATA = '0; WSTRB = '0;
    model_clear();
    test_reset();
    test_same_cycle();
    test_w_first();
    test_backpressure();
    test_out_of_range();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
